// File: rtl/banked_sram.sv
// Multi-bank simple-dual-port buffer with valid/ready handshakes, zero-init sweep and 1/2-cycle read latency.
// Optional feature: define BANKED_SRAM_RDW_BYPASS_EN to return new data on a same-address read+write collision.
module banked_sram #(
    parameter int WID    = 16,
    parameter int DEPTH  = 256,
    parameter int BANKS  = 4,
    parameter int RD_LAT = 1,
    localparam int BW    = $clog2(BANKS),
    localparam int RW    = $clog2(DEPTH),
    localparam int AW    = BW + RW
) (
    input  logic           clk,
    input  logic           rst,
    output logic           init_busy,
    input  logic           wr_valid,
    output logic           wr_ready,
    input  logic [AW-1:0]  wr_addr,
    input  logic [WID-1:0] wr_data,
    input  logic           rd_valid,
    output logic           rd_ready,
    input  logic [AW-1:0]  rd_addr,
    output logic           rd_data_valid,
    output logic [WID-1:0] rd_data
);

    typedef enum logic {INIT, RUN} state_t;

    state_t        state;
    logic [RW-1:0] rc;
    logic          sweep;

    logic          wr_fire;
    logic          rd_fire;
    logic [BW-1:0] wr_bank;
    logic [BW-1:0] rd_bank;
    logic [RW-1:0] wr_row;
    logic [RW-1:0] rd_row;

    logic [WID-1:0] bank_q [BANKS];

    assign sweep   = (state == INIT);
    assign wr_bank = wr_addr[BW-1:0];
    assign rd_bank = rd_addr[BW-1:0];
    assign wr_row  = wr_addr[AW-1:BW];
    assign rd_row  = rd_addr[AW-1:BW];

    // A request coinciding with reset is dropped even if ready is still high from RUN.
    assign wr_fire = wr_valid & wr_ready & ~rst;
    assign rd_fire = rd_valid & rd_ready & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            rc        <= '0;
            init_busy <= 1'b1;
            wr_ready  <= 1'b0;
            rd_ready  <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    rc <= rc + RW'(1);
                    if (rc == RW'(DEPTH - 1)) begin
                        state     <= RUN;
                        init_busy <= 1'b0;
                        wr_ready  <= 1'b1;
                        rd_ready  <= 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= INIT;
                    rc    <= '0;
                end
            endcase
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [WID-1:0] mem [DEPTH];
        logic [WID-1:0] rdq;
        logic           we;
        logic           re;
        logic [RW-1:0]  wrow;
        logic [WID-1:0] wdat;

        always_comb begin
            we   = 1'b0;
            wrow = wr_row;
            wdat = wr_data;
            if (sweep) begin
                we   = 1'b1;
                wrow = rc;
                wdat = '0;
            end else if (wr_fire && (wr_bank == BW'(b))) begin
                we = 1'b1;
            end
        end

        assign re = rd_fire && (rd_bank == BW'(b));

        // Read and write share one process so a same-row collision returns the pre-write word.
        always_ff @(posedge clk) begin
            if (we) begin
                mem[wrow] <= wdat;
            end
            if (re) begin
                rdq <= mem[rd_row];
            end
        end

        assign bank_q[b] = rdq;
    end

    // Stage p0: bank array output registered, bank select and valid alongside
    logic           vld_p0;
    logic [BW-1:0]  bank_p0;
    logic [WID-1:0] data_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= rd_fire;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_fire) begin
            bank_p0 <= rd_bank;
        end
    end

`ifdef BANKED_SRAM_RDW_BYPASS_EN
    logic           coll_p0;
    logic [WID-1:0] byp_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            coll_p0 <= 1'b0;
        end else begin
            coll_p0 <= wr_fire && rd_fire && (wr_addr == rd_addr);
        end
    end

    always_ff @(posedge clk) begin
        if (rd_fire) begin
            byp_p0 <= wr_data;
        end
    end

    assign data_p0 = coll_p0 ? byp_p0 : bank_q[bank_p0];
`else
    assign data_p0 = bank_q[bank_p0];
`endif

    logic           vld_last;
    logic [WID-1:0] data_last;

    if (RD_LAT == 2) begin : g_lat2
        // Stage p1: extra register for the two-cycle latency build
        logic           vld_p1;
        logic [WID-1:0] data_p1;

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_p1 <= 1'b0;
            end else begin
                vld_p1 <= vld_p0;
            end
        end

        always_ff @(posedge clk) begin
            if (vld_p0) begin
                data_p1 <= data_p0;
            end
        end

        assign vld_last  = vld_p1;
        assign data_last = data_p1;
    end else begin : g_lat1
        assign vld_last  = vld_p0;
        assign data_last = data_p0;
    end

    // Output stage: rd_data only loads on a valid result and otherwise holds
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
        end else begin
            rd_data_valid <= vld_last;
            if (vld_last) begin
                rd_data <= data_last;
            end
        end
    end

endmodule

// File: tb/tb_banked_sram.sv
// Randomised and directed bench for banked_sram against a flat-array reference model with a timed result queue.
module tb_banked_sram;
    localparam int WID    = 16;
    localparam int DEPTH  = 256;
    localparam int BANKS  = 4;
    localparam int RD_LAT = 1;
    localparam int AW     = $clog2(BANKS) + $clog2(DEPTH);
    localparam int NADDR  = 1 << AW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           init_busy;
    logic           wr_valid = 1'b0;
    logic           wr_ready;
    logic [AW-1:0]  wr_addr = '0;
    logic [WID-1:0] wr_data = '0;
    logic           rd_valid = 1'b0;
    logic           rd_ready;
    logic [AW-1:0]  rd_addr = '0;
    logic           rd_data_valid;
    logic [WID-1:0] rd_data;

    always #5 clk = ~clk;

    banked_sram #(.WID(WID), .DEPTH(DEPTH), .BANKS(BANKS), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .init_busy(init_busy),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: flat memory, count of low reset edges, queue of results due at a given edge.
    typedef struct {
        int             due;
        logic [WID-1:0] d;
    } res_t;

    logic [WID-1:0] mdl_mem [NADDR];
    res_t           pend [$];
    int             low_edges = 0;
    int             edge_n = 0;
    logic           exp_vld = 1'b0;
    logic [WID-1:0] exp_data = '0;
    bit             armed = 1'b0;

    task automatic step(input logic r, input logic wv, input int wa, input logic [WID-1:0] wd,
                        input logic rv, input int ra);
        logic [WID-1:0] d;
        rst      = r;
        wr_valid = wv;
        wr_addr  = AW'(wa);
        wr_data  = wd;
        rd_valid = rv;
        rd_addr  = AW'(ra);
        @(posedge clk);
        edge_n++;
        if (r) begin
            armed     = 1'b1;
            low_edges = 0;
            pend.delete();
            exp_vld   = 1'b0;
            exp_data  = '0;
            foreach (mdl_mem[i]) mdl_mem[i] = '0;
        end else begin
            if (low_edges >= DEPTH) begin
                if (rv) begin
                    d = mdl_mem[ra];
`ifdef BANKED_SRAM_RDW_BYPASS_EN
                    if (wv && wa == ra) d = wd;
`endif
                    pend.push_back('{due: edge_n + RD_LAT, d: d});
                end
                if (wv) mdl_mem[wa] = wd;
            end
            if (low_edges < DEPTH) low_edges++;
            if (pend.size() > 0 && pend[0].due == edge_n) begin
                exp_vld  = 1'b1;
                exp_data = pend[0].d;
                void'(pend.pop_front());
            end else begin
                exp_vld = 1'b0;
            end
        end
        @(negedge clk);
        if (armed) begin
            check("init_busy", init_busy, low_edges < DEPTH);
            check("wr_ready", wr_ready, low_edges >= DEPTH);
            check("rd_ready", rd_ready, low_edges >= DEPTH);
            check("rd_data_valid", rd_data_valid, exp_vld);
            check("rd_data", rd_data, exp_data);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, '0, 1'b0, 0);
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (wr_ready !== 1'b1 && n < DEPTH + 16) begin
            idle(1);
            n++;
        end
        check(tag, n, DEPTH);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wa;
        int ra;
        logic wv;
        logic rv;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, '0, 1'b0, 0);
        check("rst_data", rd_data, 0);
        wait_init("init_len");

        for (int a = 0; a < NADDR; a++) step(1'b0, 1'b0, 0, '0, 1'b1, a);
        idle(RD_LAT + 1);

        for (int a = 0; a < NADDR; a++) step(1'b0, 1'b1, a, WID'(16'hA000 + a), 1'b0, 0);
        for (int a = 0; a < NADDR; a++) begin
            step(1'b0, 1'b0, 0, '0, 1'b1, a);
            if (a >= RD_LAT) check("stream", rd_data, 16'hA000 + a - RD_LAT);
        end
        idle(RD_LAT + 1);

        step(1'b0, 1'b1, 5, 16'h1111, 1'b0, 0);
        step(1'b0, 1'b1, 5, 16'h2222, 1'b1, 5);
        idle(RD_LAT);
`ifdef BANKED_SRAM_RDW_BYPASS_EN
        check("collision", rd_data, 16'h2222);
`else
        check("collision", rd_data, 16'h1111);
`endif
        step(1'b0, 1'b0, 0, '0, 1'b1, 5);
        idle(RD_LAT);
        check("after_coll", rd_data, 16'h2222);

        step(1'b0, 1'b1, 8, 16'hCAFE, 1'b0, 0);
        step(1'b0, 1'b1, 4, 16'hBEEF, 1'b1, 8);
        idle(RD_LAT);
        check("diff_row_rd", rd_data, 16'hCAFE);
        step(1'b0, 1'b0, 0, '0, 1'b1, 4);
        idle(RD_LAT);
        check("diff_row_wr", rd_data, 16'hBEEF);

        for (int i = 0; i < 3000; i++) begin
            wv = 1'($urandom_range(0, 1));
            rv = 1'($urandom_range(0, 1));
            wa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, NADDR - 1));
            ra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, NADDR - 1));
            step(1'b0, wv, wa, WID'($urandom), rv, ra);
        end
        idle(RD_LAT + 1);

        step(1'b0, 1'b0, 0, '0, 1'b1, 1);
        step(1'b0, 1'b0, 0, '0, 1'b1, 2);
        step(1'b1, 1'b0, 0, '0, 1'b1, 3);
        check("rst_flush_vld", rd_data_valid, 0);
        check("rst_flush_busy", init_busy, 1);
        step(1'b1, 1'b0, 0, '0, 1'b0, 0);
        wait_init("reinit_len");
        for (int a = 0; a < 16; a++) step(1'b0, 1'b0, 0, '0, 1'b1, a);
        idle(RD_LAT);
        check("rezeroed", rd_data, 0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/banked_sram.md
# banked_sram

Parametrised, multi-bank, simple-dual-port on-chip buffer for activations and weights in the accelerator datapath. Successor to the single-bank RAM primitive, adding:
- address-interleaved banking;
- valid/ready handshakes;
- configurable read latency;
- a hardware zero-initialisation sweep after reset.

One write and one read are accepted per cycle, to any addresses.

## Interface
- `WID`, 16, data width in bits.
- `DEPTH`, 256, rows per bank; power of two, ≥ 2.
- `BANKS`, 4, bank count; power of two, 2–8.
- `RD_LAT`, 1, read latency in cycles; legal values 1 or 2.
- Derived: `BW` = `$clog2(BANKS)`, `RW` = `$clog2(DEPTH)`, `AW` = `BW` + `RW`.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `init_busy` out 1: zero-initialisation sweep in progress.
- `wr_valid` in 1: write request.
- `wr_ready` out 1: write accepted when `wr_valid` & `wr_ready`.
- `wr_addr` in `AW`: write address.
- `wr_data` in `WID`: write data.
- `rd_valid` in 1: read request.
- `rd_ready` out 1: read accepted when `rd_valid` & `rd_ready`.
- `rd_addr` in `AW`: read address.
- `rd_data_valid` out 1: `rd_data` holds the result of an accepted read.
- `rd_data` out `WID`: read data.

## Operation
- Bank select is `addr[BW-1:0]` (low-order interleave). Row is `addr[AW-1:BW]`. Consecutive addresses therefore map to consecutive banks.
- FSM states: `INIT` and `RUN`. Reset forces `INIT` with row counter = 0.
- In `INIT`:
  - every cycle, all banks write 0 to row counter `rc`, then `rc` increments;
  - when `rc` = `DEPTH-1` is written, the FSM moves to `RUN`;
  - `init_busy`=1, `wr_ready`=0, `rd_ready`=0;
  - requests are ignored and not queued.
- In `RUN`:
  - `init_busy`=0, `wr_ready`=1, `rd_ready`=1;
  - the FSM stays in `RUN` until `rst`.
- An accepted write updates only the selected bank/row at that clock edge.
- An accepted read launches a read from the selected bank. Result returned after `RD_LAT` cycles; no backpressure on the result.
- Read and write to the same address in the same cycle: old data returned (default; see Configuration).
- Read and write to different banks, or the same bank with different rows, in the same cycle: both complete, with no stall.
- `rd_data` holds its last value when `rd_data_valid`=0.
- `wr_addr` and `rd_addr` use the full `AW`-bit range, so no out-of-range address is possible.
- Row counter wrap is not reachable: the FSM exits `INIT` at `DEPTH-1`.

## Timing
- Reset values while `rst`=1 and on the first cycle after it falls:
  - `init_busy`=1;
  - `wr_ready`=0, `rd_ready`=0;
  - `rd_data_valid`=0, `rd_data`=0.
- `INIT` occupies exactly `DEPTH` cycles after the cycle in which `rst` is sampled low. Ready signals rise on cycle `DEPTH` (cycle 0 is the first low cycle).
- Read latency with `RD_LAT`=1: read accepted at edge N gives `rd_data_valid`=1 and `rd_data` after edge N+1.
- Read latency with `RD_LAT`=2: there is an additional output register stage, so data appears after edge N+2.
- Back-to-back reads at full throughput: one result per cycle, in request order.
- Write visibility: a write accepted at edge N is visible to a read accepted at edge N+1 or later.
- Reset mid-operation:
  - the in-flight read pipeline is flushed and `rd_data_valid` goes to 0;
  - memory contents are re-zeroed by a new `INIT` sweep.

## Configuration
- Macro: `BANKED_SRAM_RDW_BYPASS_EN`.
- Defined: a same-cycle, same-address read+write returns `wr_data`, i.e. the new value, with unchanged latency.
- Undefined: the same collision returns the pre-write contents.
- Different-address behaviour is identical either way.

## Test plan
- Init sweep:
  - stimulus: pulse `rst` for 3 cycles, then release, with `DEPTH`=256;
  - response: `init_busy`=1 for exactly 256 cycles, then `wr_ready`=`rd_ready`=1;
  - check: reading all 1024 addresses returns 0.
- Write/read interleave:
  - stimulus: write `addr i` with data `16'hA000+i` for i=0..1023, then read all 1024 addresses back-to-back;
  - response: every value matches, one per cycle, `rd_data_valid` continuous;
  - run with `RD_LAT`=1 and `RD_LAT`=2, checking the 1- and 2-cycle offsets respectively.
- Collision:
  - stimulus: preload `addr 5`=`16'h1111`, then read and write `addr 5` with `16'h2222` in the same cycle;
  - response: `16'h1111` without the macro, `16'h2222` with it;
  - check: a following read of `addr 5` returns `16'h2222` in both builds.
- Same-bank, different-row:
  - stimulus: write `addr 4`=`16'hBEEF` while reading `addr 8` (preloaded `16'hCAFE`);
  - response: read returns `16'hCAFE`, and a subsequent read of `addr 4` returns `16'hBEEF`.
- Reset mid-stream:
  - stimulus: assert `rst` while 2 reads are in flight;
  - response: `rd_data_valid`=0 from the next cycle, no stale result emerges, and `init_busy`=1;
  - check: after the sweep, previously written addresses read as 0.
